// File: rtl/register_scoreboard_pkg.sv
// Shared pipeline definitions for the register scoreboard.
// Holds register-address width, tracked register count, per-register in-flight
// limit and counter/total widths, plus the register-address typedefs.
package register_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W   = 4;
  localparam int unsigned NUM_REGS     = 16;
  localparam int unsigned MAX_INFLIGHT = 3;
  localparam int unsigned CNT_W        = 2;
  localparam int unsigned TOTAL_W      = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

endpackage : register_scoreboard_pkg

// File: rtl/register_scoreboard_if.sv
// Issue/retire bus between the ID stage and the register scoreboard.
// master: ID/WB side driving issue and retire info, observing stall and status.
// slave : scoreboard side.
//   issue_valid, src1/src2(+valid), dest, wb_en  -- instruction in ID
//   wb_valid, wb_dest                            -- write retiring at WB
//   issue_ready, hazard_detected                 -- combinational issue decision
//   pending, inflight_total, underflow_err       -- registered status
interface register_scoreboard_if;
  import register_scoreboard_pkg::*;

  logic                   issue_valid;
  reg_addr_t              src1;
  reg_addr_t              src2;
  logic                   src1_valid;
  logic                   src2_valid;
  reg_addr_t              dest;
  logic                   wb_en;
  logic                   wb_valid;
  reg_addr_t              wb_dest;
  logic                   issue_ready;
  logic                   hazard_detected;
  logic [NUM_REGS-1:0]    pending;
  logic [TOTAL_W-1:0]     inflight_total;
  logic                   underflow_err;

  modport master (
    output issue_valid, src1, src2, src1_valid, src2_valid, dest, wb_en,
    output wb_valid, wb_dest,
    input  issue_ready, hazard_detected, pending, inflight_total, underflow_err
  );

  modport slave (
    input  issue_valid, src1, src2, src1_valid, src2_valid, dest, wb_en,
    input  wb_valid, wb_dest,
    output issue_ready, hazard_detected, pending, inflight_total, underflow_err
  );

endinterface : register_scoreboard_if

// File: rtl/register_scoreboard_sb_counter.sv
// sb_counter: one register's in-flight write counter.
// Saturating up at MAX_INFLIGHT, never below zero. inc and a real dec on the
// same edge cancel. underflow_c flags a dec seen while the count is zero.
// Ports: clk, rst (async high), inc, dec, cnt (state), cnt_next_c, underflow_c.
module sb_counter
  import register_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output cnt_t cnt,
  output cnt_t cnt_next_c,
  output logic underflow_c
);

  cnt_t cnt_q;
  logic dec_ok;

  assign dec_ok      = dec && (cnt_q != '0);
  assign underflow_c = dec && (cnt_q == '0);
  assign cnt         = cnt_q;

  // Next count from the inc / effective-dec pair
  always_comb begin
    cnt_next_c = cnt_q;
    unique case ({inc, dec_ok})
      2'b10: if (cnt_q != CNT_W'(MAX_INFLIGHT)) cnt_next_c = cnt_t'(cnt_q + 1'b1);
      2'b01: cnt_next_c = cnt_t'(cnt_q - 1'b1);
      default: cnt_next_c = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_next_c;
  end

endmodule : sb_counter

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register in-flight write tracker beside ID.
// Counts pending destination writes (inc at issue, dec at WB retire), decides
// whether the ID instruction may issue and raises the IF/ID stall otherwise.
// Ports: clk, rst (async high), bus (register_scoreboard_if.slave).
module register_scoreboard
  import register_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  register_scoreboard_if.slave  bus
);

  cnt_t                cnt      [NUM_REGS];
  cnt_t                cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] uflow_vec;

  logic                src1_hazard;
  logic                src2_hazard;
  logic                dest_sat;
  logic                issue_ready_c;
  logic                issue_acc;
  logic                retire_ok;

  logic [NUM_REGS-1:0] pending_q;
  logic [TOTAL_W-1:0]  total_q;
  logic                underflow_q;
  logic [NUM_REGS-1:0] pending_next;

  // Source hazard, released when the last outstanding write retires this
  // cycle (write-through register file makes it visible to ID).
  always_comb begin
    src1_hazard = bus.src1_valid && (cnt[bus.src1] != '0) &&
                  !(bus.wb_valid && (bus.wb_dest == bus.src1) && (cnt[bus.src1] == CNT_W'(1)));
    src2_hazard = bus.src2_valid && (cnt[bus.src2] != '0) &&
                  !(bus.wb_valid && (bus.wb_dest == bus.src2) && (cnt[bus.src2] == CNT_W'(1)));
    dest_sat    = bus.wb_en && (cnt[bus.dest] == CNT_W'(MAX_INFLIGHT)) &&
                  !(bus.wb_valid && (bus.wb_dest == bus.dest));
  end

  assign issue_ready_c       = !src1_hazard && !src2_hazard && !dest_sat;
  assign issue_acc           = bus.issue_valid && issue_ready_c && bus.wb_en;
  assign retire_ok           = bus.wb_valid && (cnt[bus.wb_dest] != '0);
  assign bus.issue_ready     = issue_ready_c;
  assign bus.hazard_detected = bus.issue_valid && !issue_ready_c;

  // One counter per architectural register
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc         (issue_acc && (bus.dest == reg_addr_t'(r))),
      .dec         (bus.wb_valid && (bus.wb_dest == reg_addr_t'(r))),
      .cnt         (cnt[r]),
      .cnt_next_c  (cnt_next[r]),
      .underflow_c (uflow_vec[r])
    );
    assign pending_next[r] = (cnt_next[r] != '0);
  end

  // Registered status, updated on the same edge as the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      total_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      pending_q   <= pending_next;
      total_q     <= TOTAL_W'(total_q + TOTAL_W'(issue_acc) - TOTAL_W'(retire_ok));
      underflow_q <= underflow_q || (|uflow_vec);
    end
  end

  assign bus.pending        = pending_q;
  assign bus.inflight_total = total_q;
  assign bus.underflow_err  = underflow_q;

endmodule : register_scoreboard

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: each stimulus slot pushes its expected
// outputs into a queue; a negedge monitor pops and compares.
module tb_register_scoreboard;
  import register_scoreboard_pkg::*;

  typedef struct packed {
    int          cyc;
    logic        ir;
    logic        hz;
    logic [15:0] pend;
    logic [3:0]  tot;
    logic        ue;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  exp_t  exp_q[$];
  string name_q[$];

  register_scoreboard_if sb_if ();

  register_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (sb_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", nm, e.cyc, cyc);
      end else if (sb_if.issue_ready !== e.ir || sb_if.hazard_detected !== e.hz ||
                   sb_if.pending !== e.pend || sb_if.inflight_total !== e.tot ||
                   sb_if.underflow_err !== e.ue) begin
        n_fail++;
        $display("FAIL %s: got ir=%b hz=%b pend=%h tot=%0d ue=%b, expected ir=%b hz=%b pend=%h tot=%0d ue=%b",
                 nm, sb_if.issue_ready, sb_if.hazard_detected, sb_if.pending,
                 sb_if.inflight_total, sb_if.underflow_err,
                 e.ir, e.hz, e.pend, e.tot, e.ue);
      end
    end
  end

  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input reg_addr_t s1, input logic s1v,
                       input reg_addr_t s2, input logic s2v, input reg_addr_t d,
                       input logic we, input logic wv, input reg_addr_t wd);
    sb_if.issue_valid = iv;
    sb_if.src1        = s1;
    sb_if.src1_valid  = s1v;
    sb_if.src2        = s2;
    sb_if.src2_valid  = s2v;
    sb_if.dest        = d;
    sb_if.wb_en       = we;
    sb_if.wb_valid    = wv;
    sb_if.wb_dest     = wd;
  endtask

  task automatic expect_out(input string nm, input logic ir, input logic hz,
                            input logic [15:0] pend, input logic [3:0] tot, input logic ue);
    exp_t e;
    e.cyc = cyc; e.ir = ir; e.hz = hz; e.pend = pend; e.tot = tot; e.ue = ue;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic issue_w(input reg_addr_t d);
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, d, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic retire(input reg_addr_t wd);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, wd);
  endtask

  initial begin
    idle();
    // Reset state
    slot(); expect_out("reset", 1, 0, 16'h0000, 0, 0);

    // Issue R1, observe, retire
    slot(); rst = 1'b0; issue_w(4'd1); expect_out("issue_r1", 1, 0, 16'h0000, 0, 0);
    slot(); idle();       expect_out("r1_pending", 1, 0, 16'h0002, 1, 0);
    slot(); retire(4'd1); expect_out("r1_retire_cycle", 1, 0, 16'h0002, 1, 0);
    slot(); idle();       expect_out("r1_retired", 1, 0, 16'h0000, 0, 0);

    // RAW on R2: stall until producer's WB cycle
    slot(); issue_w(4'd2); expect_out("issue_r2", 1, 0, 16'h0000, 0, 0);
    slot(); drive(1, 4'd2, 1, 4'd0, 0, 4'd7, 1, 0, 4'd0); expect_out("raw_stall1", 0, 1, 16'h0004, 1, 0);
    slot(); expect_out("raw_stall2", 0, 1, 16'h0004, 1, 0);
    slot(); drive(1, 4'd2, 1, 4'd0, 0, 4'd7, 1, 1, 4'd2); expect_out("raw_release", 1, 0, 16'h0004, 1, 0);
    slot(); retire(4'd7); expect_out("r7_after_release", 1, 0, 16'h0080, 1, 0);

    // Same-edge issue and retire on R3 with cnt=2
    slot(); issue_w(4'd3); expect_out("r3_issue_a", 1, 0, 16'h0000, 0, 0);
    slot(); issue_w(4'd3); expect_out("r3_issue_b", 1, 0, 16'h0008, 1, 0);
    slot(); drive(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 4'd3); expect_out("r3_issue_retire", 1, 0, 16'h0008, 2, 0);
    slot(); idle(); expect_out("r3_unchanged", 1, 0, 16'h0008, 2, 0);

    // R4 saturation
    slot(); issue_w(4'd4); expect_out("r4_issue_1", 1, 0, 16'h0008, 2, 0);
    slot(); issue_w(4'd4); expect_out("r4_issue_2", 1, 0, 16'h0018, 3, 0);
    slot(); issue_w(4'd4); expect_out("r4_issue_3", 1, 0, 16'h0018, 4, 0);
    slot(); issue_w(4'd4); expect_out("r4_saturated", 0, 1, 16'h0018, 5, 0);
    slot(); drive(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 1, 4'd4); expect_out("r4_sat_with_retire", 1, 0, 16'h0018, 5, 0);
    slot(); idle(); expect_out("r4_total_held", 1, 0, 16'h0018, 5, 0);
    slot(); issue_w(4'd4); expect_out("r4_still_full", 0, 1, 16'h0018, 5, 0);

    // Immediate operand on R5 does not stall; real src2 does
    slot(); issue_w(4'd5); expect_out("r5_issue", 1, 0, 16'h0018, 5, 0);
    slot(); drive(1, 4'd0, 1, 4'd5, 0, 4'd0, 0, 0, 4'd0); expect_out("src2_imm_no_hazard", 1, 0, 16'h0038, 6, 0);
    slot(); drive(1, 4'd0, 1, 4'd5, 1, 4'd0, 0, 0, 4'd0); expect_out("src2_real_hazard", 0, 1, 16'h0038, 6, 0);

    // Underflow on R6
    slot(); retire(4'd6); expect_out("r6_underflow_cycle", 1, 0, 16'h0038, 6, 0);
    slot(); idle();       expect_out("underflow_sticky", 1, 0, 16'h0038, 6, 1);

    // Async reset mid-stall
    slot(); drive(1, 4'd4, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0); expect_out("stall_before_rst", 0, 1, 16'h0038, 6, 1);
    slot(); rst = 1'b1; #1; expect_out("async_rst_mid_stall", 1, 0, 16'h0000, 0, 0);
    slot(); rst = 1'b0; idle(); expect_out("after_rst", 1, 0, 16'h0000, 0, 0);

    // Let the monitor drain; leftovers count as failures
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      string nm;
      void'(exp_q.pop_front());
      nm = name_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never sampled", nm);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_register_scoreboard
